// File: rtl/l2_frame_pkg.sv
// Shared L2 frame definitions: frame geometry, field positions, SFD and
// broadcast constants, and the ingress receiver state encoding.
package l2_frame_pkg;

   localparam int unsigned DEPTH      = 16;
   localparam int unsigned ADDR_WIDTH = 4;

   localparam logic [3:0]            SFD_VALUE      = 4'h5;
   localparam logic [ADDR_WIDTH-1:0] BROADCAST_ADDR = '1;

   // Field positions within a frame, MSB first on the wire
   localparam int unsigned SFD_MSB     = 15;
   localparam int unsigned SFD_LSB     = 12;
   localparam int unsigned DST_MSB     = 11;
   localparam int unsigned DST_LSB     = 8;
   localparam int unsigned SRC_MSB     = 7;
   localparam int unsigned SRC_LSB     = 4;
   localparam int unsigned PAYLOAD_MSB = 3;
   localparam int unsigned PAYLOAD_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      CHECK = 2'b10
   } state_t;

endpackage

// File: rtl/frame_fifo.sv
// First-word-fall-through frame buffer.
// Ports: clk, rst (sync, active-high); push/push_data write side;
// pop/pop_data read side (pop_data valid while !empty, zero when empty);
// full, empty, level occupancy status.
// A push while full is accepted only when a pop happens in the same cycle.
module frame_fifo #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ENTRIES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(ENTRIES):0]   level
);

   localparam int unsigned AW = $clog2(ENTRIES);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [ENTRIES];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign full     = (level == LW'(ENTRIES));
   assign empty    = (level == '0);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage array, not reset: contents are qualified by level
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally since ENTRIES is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/switch_ingress_port.sv
// Ingress stage of one L2 switch port: deserialises MSB-first 16-bit frames
// from an idle-high serial line, rejects bad SFDs, emits source-learning
// pulses and buffers good frames for the forwarding fabric.
// Ports: clk, rst (sync, active-high), rx_bit serial input;
// out_frame/out_valid/out_ready/out_port fabric handshake;
// learn_valid/learn_addr learning event; fifo_level occupancy;
// sfd_err_cnt/drop_cnt saturating statistics; busy while receiving.
module switch_ingress_port
   import l2_frame_pkg::*;
#(
   parameter int unsigned            FIFO_DEPTH = 4,
   parameter int unsigned            PORT_WIDTH = 2,
   parameter logic [PORT_WIDTH-1:0]  PORT_ID    = '0,
   parameter int unsigned            CNT_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_bit,
   output logic [DEPTH-1:0]              out_frame,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PORT_WIDTH-1:0]         out_port,
   output logic                          learn_valid,
   output logic [ADDR_WIDTH-1:0]         learn_addr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_WIDTH-1:0]          sfd_err_cnt,
   output logic [CNT_WIDTH-1:0]          drop_cnt,
   output logic                          busy
);

   localparam int unsigned BCW = $clog2(DEPTH);

   state_t                state;
   state_t                state_nx;
   logic [BCW-1:0]        bit_cnt;
   logic [BCW-1:0]        bit_cnt_nx;
   logic                  rx_bit_d1;
   logic [DEPTH-1:0]      shreg;
   logic [3:0]            sfd;
   logic [ADDR_WIDTH-1:0] src;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  sfd_err_hit;
   logic                  drop_hit;
   logic                  learn_hit;

   assign sfd       = shreg[SFD_MSB:SFD_LSB];
   assign src       = shreg[SRC_MSB:SRC_LSB];
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign out_port  = PORT_ID;

   // State register and bit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
      end
   end

   // Next-state and frame disposition
   always_comb begin
      state_nx    = state;
      bit_cnt_nx  = bit_cnt;
      push        = 1'b0;
      sfd_err_hit = 1'b0;
      drop_hit    = 1'b0;
      learn_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (rx_bit_d1 && !rx_bit) begin
               state_nx   = SHIFT;
               bit_cnt_nx = BCW'(DEPTH - 1);
            end
         end
         SHIFT: begin
            // Start cycle already consumed one count; exit after bit 0 lands
            bit_cnt_nx = bit_cnt - BCW'(1);
            if (bit_cnt == BCW'(1)) state_nx = CHECK;
         end
         CHECK: begin
            state_nx = IDLE;
            if (sfd != SFD_VALUE) begin
               sfd_err_hit = 1'b1;
            end else if (fifo_full && !out_ready) begin
               drop_hit = 1'b1;
            end else begin
               push      = 1'b1;
               learn_hit = (src != BROADCAST_ADDR);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Line history and free-running deserialiser
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_bit_d1 <= 1'b1;
         shreg     <= '0;
      end else begin
         rx_bit_d1 <= rx_bit;
         shreg     <= {shreg[DEPTH-2:0], rx_bit};
      end
   end

   // Learning event, busy flag and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         learn_valid <= 1'b0;
         learn_addr  <= '0;
         busy        <= 1'b0;
         sfd_err_cnt <= '0;
         drop_cnt    <= '0;
      end else begin
         learn_valid <= learn_hit;
         if (learn_hit) learn_addr <= src;
         busy <= (state_nx != IDLE);
         if (sfd_err_hit && (sfd_err_cnt != '1)) sfd_err_cnt <= sfd_err_cnt + CNT_WIDTH'(1);
         if (drop_hit && (drop_cnt != '1))       drop_cnt    <= drop_cnt + CNT_WIDTH'(1);
      end
   end

   frame_fifo #(
      .WIDTH   (DEPTH),
      .ENTRIES (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shreg),
      .pop       (pop),
      .pop_data  (out_frame),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

endmodule

// File: tb/tb_switch_ingress_port.sv
// Self-checking bench for switch_ingress_port: directed scenarios plus
// randomized frames, compared every cycle against a frame-level model.
module tb_switch_ingress_port;

   logic        clk;
   logic        rst;
   logic        rx_bit;
   logic [15:0] out_frame;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_port;
   logic        learn_valid;
   logic [3:0]  learn_addr;
   logic [2:0]  fifo_level;
   logic [7:0]  sfd_err_cnt;
   logic [7:0]  drop_cnt;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int ready_mode = 1;   // 0 random, 1 always high, 2 always low

   switch_ingress_port #(
      .FIFO_DEPTH (4),
      .PORT_WIDTH (2),
      .PORT_ID    (2'd2),
      .CNT_WIDTH  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_bit      (rx_bit),
      .out_frame   (out_frame),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_port    (out_port),
      .learn_valid (learn_valid),
      .learn_addr  (learn_addr),
      .fifo_level  (fifo_level),
      .sfd_err_cnt (sfd_err_cnt),
      .drop_cnt    (drop_cnt),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: frames collected bit by bit from the line, disposed of at
   // the cycle after the 16th bit, buffered in a queue popped by the handshake.
   logic [15:0] q[$];
   int          m_err, m_drop, m_n;
   logic [15:0] m_bits;
   logic        m_prev, m_learn, m_live, m_pop, m_push;
   logic [3:0]  m_laddr;

   initial begin
      m_live = 1'b0;
      m_n    = 0;
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("out_valid", out_valid, (q.size() != 0));
         if (q.size() != 0) check("out_frame", out_frame, q[0]);
         check("fifo_level", fifo_level, q.size());
         check("learn_valid", learn_valid, m_learn);
         if (m_learn) check("learn_addr", learn_addr, m_laddr);
         check("sfd_err_cnt", sfd_err_cnt, m_err);
         check("drop_cnt", drop_cnt, m_drop);
         check("busy", busy, (m_n > 0));
         check("out_port", out_port, 2'd2);
      end
      if (rst) begin
         q.delete();
         m_err = 0; m_drop = 0; m_n = 0;
         m_prev = 1'b1; m_learn = 1'b0; m_laddr = 4'h0;
         m_live = 1'b1;
      end else if (m_live) begin
         m_pop   = (q.size() != 0) && out_ready;
         m_push  = 1'b0;
         m_learn = 1'b0;
         if (m_n == 16) begin
            if (m_bits[15:12] != 4'h5) begin
               if (m_err < 255) m_err++;
            end else if (q.size() == 4 && !out_ready) begin
               if (m_drop < 255) m_drop++;
            end else begin
               m_push = 1'b1;
               if (m_bits[7:4] != 4'hF) begin
                  m_learn = 1'b1;
                  m_laddr = m_bits[7:4];
               end
            end
            m_n = 0;
         end else if (m_n > 0) begin
            m_bits[15-m_n] = rx_bit;
            m_n++;
         end else if (m_prev && !rx_bit) begin
            m_bits     = 16'h0;
            m_bits[15] = rx_bit;
            m_n        = 1;
         end
         if (m_pop)  void'(q.pop_front());
         if (m_push) q.push_back(m_bits);
         m_prev = rx_bit;
      end
   end

   // One clock of stimulus; ov >= 0 overrides out_ready for this cycle
   task automatic step(input logic line, input int ov = -1, input logic r = 1'b0);
      @(posedge clk);
      #1;
      rx_bit = line;
      rst    = r;
      if (ov >= 0)              out_ready = ov[0];
      else if (ready_mode == 0) out_ready = (($urandom % 4) == 0);
      else if (ready_mode == 1) out_ready = 1'b1;
      else                      out_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1);
   endtask

   // Serialise a frame; optional reset at bit rst_at; rdy16 forces out_ready in T16
   task automatic send_frame(input logic [15:0] f, input int gap,
                             input int rst_at = -1, input int rdy16 = -1);
      for (int i = 0; i < 16; i++) begin
         if (i == rst_at) begin
            step(1'b1, -1, 1'b1);
            return;
         end
         step(f[15-i]);
      end
      for (int g = 0; g < gap; g++) step(1'b1, (g == 0) ? rdy16 : -1);
   endtask

   initial begin
      logic [15:0] f;
      rst = 1'b1; rx_bit = 1'b1; out_ready = 1'b0;
      step(1'b1, -1, 1'b1);
      step(1'b1, -1, 1'b1);
      step(1'b1);
      @(negedge clk);
      check("rst_out_frame", out_frame, 16'h0);
      check("rst_out_valid", out_valid, 1'b0);

      // Single good frame, popped as soon as it appears
      ready_mode = 1;
      send_frame(16'h5312, 3);
      idle(4);

      // Bad SFD
      send_frame(16'h7312, 3);
      idle(2);
      @(negedge clk);
      check("sfd_err_after_bad", sfd_err_cnt, 8'd1);

      // Fill with no reader; fifth frame dropped, then drain
      ready_mode = 2;
      for (int i = 1; i <= 5; i++) send_frame(16'h5010 + 16'(i), 1);
      idle(2);
      @(negedge clk);
      check("full_level", fifo_level, 3'd4);
      check("full_drop", drop_cnt, 8'd1);
      ready_mode = 1;
      idle(8);

      // Full with reader present in the push cycle: no drop, order over wrap
      ready_mode = 2;
      for (int i = 1; i <= 4; i++) send_frame(16'h5020 + 16'(i), 1);
      send_frame(16'h5025, 2, -1, 1);
      @(negedge clk);
      check("full_pass_level", fifo_level, 3'd4);
      check("full_pass_drop", drop_cnt, 8'd1);
      ready_mode = 1;
      idle(8);

      // Broadcast source: stored, not learned
      send_frame(16'h53F2, 3);
      idle(4);

      // Line held low after a frame: no restart until a fresh falling edge
      send_frame(16'h5310, 0);
      step(1'b0); step(1'b0); step(1'b0);
      idle(3);

      // Reset mid-frame, then a clean frame
      send_frame(16'h5312, 0, 8);
      send_frame(16'h5444, 3);
      idle(3);
      @(negedge clk);
      check("post_rst_err", sfd_err_cnt, 8'd0);
      check("post_rst_drop", drop_cnt, 8'd0);

      // Randomized traffic
      ready_mode = 0;
      for (int n = 0; n < 80; n++) begin
         f = 16'($urandom);
         f[15:12] = (($urandom % 4) == 0) ? {1'b0, 3'($urandom)} : 4'h5;
         send_frame(f, 1 + int'($urandom % 3), -1, (($urandom % 5) == 0) ? 1 : -1);
      end
      ready_mode = 1;
      idle(10);

      // Error counter saturation
      step(1'b1, -1, 1'b1);
      idle(1);
      for (int n = 0; n < 260; n++) send_frame(16'h7000, 1);
      idle(2);
      @(negedge clk);
      check("sfd_err_sat", sfd_err_cnt, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_ingress_port.md
Name: switch_ingress_port

Overview:
- Switch-side receive stage for one L2 switch port, directly downstream of an end device's serial TX output.
- Deserialises 16-bit frames arriving MSB-first on an idle-high serial line.
- Validates the SFD, emits a source-address learning pulse, and buffers good frames in a small FIFO.
- Presents frames to the forwarding fabric over a valid/ready handshake; keeps saturating error and drop counters.

Parameters:
- DEPTH, 16, frame width in bits.
- ADDR_WIDTH, 4, MAC address field width.
- SFD_VALUE, 4'h5, required start-of-frame delimiter; its MSB must be 0.
- FIFO_DEPTH, 4, frame buffer entries; power of two, at least 2.
- PORT_WIDTH, 2, width of the port identifier.
- PORT_ID, 2'd0, this port's number, attached to every output frame and learn event.
- CNT_WIDTH, 8, width of the statistics counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- rx_bit  in  1  serial line; idle high.
- out_frame  out  DEPTH  head-of-FIFO frame.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  fabric accepts out_frame this cycle.
- out_port  out  PORT_WIDTH  equals PORT_ID.
- learn_valid  out  1  one-cycle source-learning pulse.
- learn_addr  out  ADDR_WIDTH  source address of the learned frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- sfd_err_cnt  out  CNT_WIDTH  frames rejected for a bad SFD.
- drop_cnt  out  CNT_WIDTH  good frames lost because the FIFO was full.
- busy  out  1  high in SHIFT or CHECK.

Behaviour:
- Frame layout: [15:12] SFD, [11:8] DST, [7:4] SRC, [3:0] PAYLOAD.
- Reset (synchronous, one cycle):
  - State returns to IDLE; the internal rx_bit_d1 register is set to 1.
  - The shift register is cleared and the FIFO is emptied.
  - All outputs are 0 except out_port, which is PORT_ID.
- IDLE:
  - A start is detected when rx_bit_d1==1 and rx_bit==0; call that cycle T0.
  - The bit present in cycle T0+n is frame bit 15-n, for n=0..15.
  - The shift register shifts rx_bit in every cycle unconditionally.
- SHIFT:
  - A down-counter is loaded with DEPTH-1 at T0; the state machine remains in SHIFT through T15.
  - Line transitions during SHIFT and CHECK are ignored.
- CHECK (cycle T16):
  - If SFD != SFD_VALUE: sfd_err_cnt increments (saturating) and no push occurs.
  - Else if the FIFO is full and out_ready is low: drop_cnt increments (saturating) and no push occurs.
  - Else: the frame is pushed at the end of T16 and learn_valid pulses in T17 with learn_addr = SRC.
  - No learn pulse is generated when SRC is all-ones (broadcast); the frame is still pushed.
  - The state returns to IDLE unconditionally.
- Gap and latency:
  - The minimum inter-frame gap is one high cycle: line high in T16, next T0 at T17 or later.
  - A line that stays low through T16 causes no new start until a high-to-low transition is seen.
- FIFO:
  - First-word-fall-through; out_frame is valid whenever out_valid is high.
  - A pop occurs when out_valid && out_ready.
  - Simultaneous push and pop is permitted at any level, including full; the level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency: frame start T0 to out_valid with an empty FIFO is 17 cycles (visible in T17).
- Counters saturate at all-ones and are cleared only by rst.
- Reset asserted mid-frame aborts the frame: no push, no counter change, no learn pulse.

Decomposition:
- Package l2_frame_pkg holds:
  - DEPTH, ADDR_WIDTH, SFD_VALUE and BROADCAST_ADDR.
  - Field MSB/LSB constants for SFD, DST, SRC and PAYLOAD.
  - The state encoding IDLE=2'b00, SHIFT=2'b01, CHECK=2'b10.
- Sub-module frame_fifo:
  - Parameterised by width and depth.
  - Provides push/pop, full/empty and level.
  - Reusable by the egress stage.
- Deserialiser, state machine and counters stay in the top module.

Test Plan:
- Reset, then send frame 0x5312 with out_ready=1 -> learn_valid in T17 with learn_addr=1; out_valid in T17 with out_frame=0x5312 and out_port=PORT_ID; popped the same cycle; fifo_level returns to 0.
- Send frame 0x7312 (SFD=7) -> sfd_err_cnt=1; out_valid stays 0; no learn pulse.
- Hold out_ready=0 and send 5 frames 0x5011..0x5015 with 1-cycle gaps -> fifo_level=4; drop_cnt=1; the 5th frame is lost; draining yields 0x5011, 0x5012, 0x5013, 0x5014 in order.
- FIFO full with out_ready=1 in the push cycle of a 5th good frame -> no drop; fifo_level stays 4; order is preserved across pointer wrap.
- Send frame 0x53F2 (SRC=F) -> frame is buffered; learn_valid stays 0.
- Assert rst at T8 of frame 0x5312, then send 0x5444 -> nothing is stored from the first frame; 0x5444 is received correctly; counters remain 0.
